// File: rtl/timer_pkg.sv
// Shared definitions for the N-channel timer bank: register map, TCR/TCSR
// bit positions, clear-on-compare selector and reset values.
package timer_pkg;

  localparam logic [2:0] OFF_TCNT  = 3'd0;
  localparam logic [2:0] OFF_TCORA = 3'd1;
  localparam logic [2:0] OFF_TCORB = 3'd2;
  localparam logic [2:0] OFF_TCR   = 3'd3;
  localparam logic [2:0] OFF_TCSR  = 3'd4;

  localparam int TCR_CMIEA   = 0;
  localparam int TCR_CMIEB   = 1;
  localparam int TCR_OVIE    = 2;
  localparam int TCR_CCLR_LO = 3;
  localparam int TCR_CASC    = 5;
  localparam int TCR_ONESHOT = 6;
  localparam int TCR_RUN     = 7;

  localparam int TCSR_CMFA = 0;
  localparam int TCSR_CMFB = 1;
  localparam int TCSR_OVF  = 2;

  localparam logic [7:0] TCR_RST  = 8'h00;
  localparam logic [2:0] TCSR_RST = 3'b000;

  typedef enum logic [1:0] {
    CCLR_NONE = 2'b00,
    CCLR_A    = 2'b01,
    CCLR_B    = 2'b10
  } cclr_e;

  // Encoding 2'b11 is reserved and behaves as "no clear".
  function automatic cclr_e decode_cclr(input logic [1:0] field);
    cclr_e sel;
    case (field)
      2'b01:   sel = CCLR_A;
      2'b10:   sel = CCLR_B;
      default: sel = CCLR_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/timer_chan.sv
// One timer channel: counter, two compare registers, control/status
// registers, event pulses and the cascade overflow tap.
module timer_chan
  import timer_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter bit CASC_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [2:0]       wr_off,
  input  logic [CNT_W-1:0] wr_data,
  input  logic             tick,
  input  logic             casc_in,
  output logic             ovf_evt,
  output logic [CNT_W-1:0] tcnt,
  output logic [CNT_W-1:0] tcora,
  output logic [CNT_W-1:0] tcorb,
  output logic [7:0]       tcr,
  output logic [2:0]       tcsr,
  output logic             cma,
  output logic             cmb,
  output logic             ovf,
  output logic             irq
);

  logic [CNT_W-1:0] tcnt_r, tcora_r, tcorb_r;
  logic [7:0]       tcr_r;
  logic [2:0]       tcsr_r;
  logic             cma_r, cmb_r, ovf_r;

  logic  wr_tcnt_s, eff_tick_s, count_s, match_a_s, match_b_s, clr_s, ovf_s;
  logic  [2:0] w1c_s;
  cclr_e cclr_s;

  // Event evaluation on the pre-edge counter value; a TCNT write swallows the tick.
  always_comb begin
    wr_tcnt_s  = wr_en && (wr_off == OFF_TCNT);
    eff_tick_s = (CASC_EN && tcr_r[TCR_CASC]) ? casc_in : tick;
    count_s    = tcr_r[TCR_RUN] && eff_tick_s && !wr_tcnt_s;
    match_a_s  = count_s && (tcnt_r == tcora_r);
    match_b_s  = count_s && (tcnt_r == tcorb_r);
    cclr_s     = decode_cclr(tcr_r[TCR_CCLR_LO+1:TCR_CCLR_LO]);
    clr_s      = ((cclr_s == CCLR_A) && match_a_s) || ((cclr_s == CCLR_B) && match_b_s);
    ovf_s      = count_s && (tcnt_r == {CNT_W{1'b1}}) && !clr_s;
    w1c_s      = (wr_en && (wr_off == OFF_TCSR)) ? wr_data[2:0] : 3'b000;
  end

  // Channel register state and registered event pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tcnt_r  <= {CNT_W{1'b0}};
      tcora_r <= {CNT_W{1'b1}};
      tcorb_r <= {CNT_W{1'b1}};
      tcr_r   <= TCR_RST;
      tcsr_r  <= TCSR_RST;
      cma_r   <= 1'b0;
      cmb_r   <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      if (wr_tcnt_s) begin
        tcnt_r <= wr_data;
      end else if (count_s) begin
        tcnt_r <= clr_s ? {CNT_W{1'b0}} : tcnt_r + CNT_W'(1'b1);
      end
      if (wr_en && (wr_off == OFF_TCORA)) tcora_r <= wr_data;
      if (wr_en && (wr_off == OFF_TCORB)) tcorb_r <= wr_data;
      // A bus write to TCR overrides the one-shot RUN clear.
      if (wr_en && (wr_off == OFF_TCR)) begin
        tcr_r <= wr_data[7:0];
      end else if (tcr_r[TCR_ONESHOT] && match_a_s) begin
        tcr_r[TCR_RUN] <= 1'b0;
      end
      tcsr_r <= (tcsr_r & ~w1c_s) | {ovf_s, match_b_s, match_a_s};
      cma_r  <= match_a_s;
      cmb_r  <= match_b_s;
      ovf_r  <= ovf_s;
    end
  end

  assign ovf_evt = ovf_s;
  assign tcnt    = tcnt_r;
  assign tcora   = tcora_r;
  assign tcorb   = tcorb_r;
  assign tcr     = tcr_r;
  assign tcsr    = tcsr_r;
  assign cma     = cma_r;
  assign cmb     = cmb_r;
  assign ovf     = ovf_r;
  // Flag and enable bits share positions 0..2, so a bitwise AND pairs them.
  assign irq     = |(tcsr_r & tcr_r[2:0]);

endmodule

// File: rtl/timer_bank_n.sv
// N-channel timer register bank: address decode, cascade wiring and the
// registered read path in front of the per-channel timer cores.
module timer_bank_n
  import timer_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int CNT_W  = 16,
  parameter int BUS_W  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk_sys,
  input  logic              i_rst,
  input  logic              i_wren,
  input  logic              i_rden,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [BUS_W-1:0]  i_wdata,
  input  logic [N_CH-1:0]   i_tick,
  output logic [BUS_W-1:0]  o_rdata,
  output logic              o_rvalid,
  output logic [N_CH-1:0]   o_cma,
  output logic [N_CH-1:0]   o_cmb,
  output logic [N_CH-1:0]   o_ovf,
  output logic [N_CH-1:0]   o_irq
);

  localparam int CH_W = ADDR_W - 3;

  logic [CH_W-1:0]  chan_s;
  logic [2:0]       off_s;
  logic [BUS_W-1:0] rd_val_a [N_CH];
  logic [BUS_W-1:0] rd_mux_s;
  logic [BUS_W-1:0] rdata_r;
  logic             rvalid_r;

  assign chan_s = i_addr[ADDR_W-1:3];
  assign off_s  = i_addr[2:0];

  function automatic logic [BUS_W-1:0] sel_reg(
    input logic [2:0]       off,
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] cora,
    input logic [CNT_W-1:0] corb,
    input logic [7:0]       ctl,
    input logic [2:0]       sts
  );
    logic [BUS_W-1:0] val;
    case (off)
      OFF_TCNT:  val = BUS_W'(cnt);
      OFF_TCORA: val = BUS_W'(cora);
      OFF_TCORB: val = BUS_W'(corb);
      OFF_TCR:   val = BUS_W'(ctl);
      OFF_TCSR:  val = BUS_W'(sts);
      default:   val = {BUS_W{1'b0}};
    endcase
    return val;
  endfunction

  for (genvar k = 0; k < N_CH; k++) begin : gen_ch
    logic             wr_s, casc_s, ovf_evt_s;
    logic [CNT_W-1:0] tcnt_s, tcora_s, tcorb_s;
    logic [7:0]       tcr_s;
    logic [2:0]       tcsr_s;

    assign wr_s = i_wren && (chan_s == CH_W'(k));

    // Cascade is a same-cycle combinational chain from the lower channel.
    if (k == 0) begin : g_head
      assign casc_s = 1'b0;
    end else begin : g_link
      assign casc_s = gen_ch[k-1].ovf_evt_s;
    end

    timer_chan #(
      .CNT_W   (CNT_W),
      .CASC_EN (k != 0)
    ) u_chan (
      .clk     (i_clk_sys),
      .rst     (i_rst),
      .wr_en   (wr_s),
      .wr_off  (off_s),
      .wr_data (i_wdata[CNT_W-1:0]),
      .tick    (i_tick[k]),
      .casc_in (casc_s),
      .ovf_evt (ovf_evt_s),
      .tcnt    (tcnt_s),
      .tcora   (tcora_s),
      .tcorb   (tcorb_s),
      .tcr     (tcr_s),
      .tcsr    (tcsr_s),
      .cma     (o_cma[k]),
      .cmb     (o_cmb[k]),
      .ovf     (o_ovf[k]),
      .irq     (o_irq[k])
    );

    assign rd_val_a[k] = sel_reg(off_s, tcnt_s, tcora_s, tcorb_s, tcr_s, tcsr_s);
  end

  if (BUS_W > CNT_W) begin : g_pad
    logic unused_s;
    assign unused_s = ^i_wdata[BUS_W-1:CNT_W];
  end

  // Channel select for reads; channels beyond N_CH fall through to zero.
  always_comb begin
    rd_mux_s = {BUS_W{1'b0}};
    for (int k = 0; k < N_CH; k++) begin
      rd_mux_s = rd_mux_s | ((chan_s == CH_W'(k)) ? rd_val_a[k] : {BUS_W{1'b0}});
    end
  end

  // Registered read port capturing pre-edge register contents.
  always_ff @(posedge i_clk_sys or posedge i_rst) begin
    if (i_rst) begin
      rdata_r  <= {BUS_W{1'b0}};
      rvalid_r <= 1'b0;
    end else begin
      rvalid_r <= i_rden;
      if (i_rden) rdata_r <= rd_mux_s;
    end
  end

  assign o_rdata  = rdata_r;
  assign o_rvalid = rvalid_r;

endmodule

// File: tb/tb_timer_bank_n.sv
// Randomized scoreboard bench for timer_bank_n against a behavioural
// register-bank model.
module tb_timer_bank_n;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int BW = 32;
  localparam int AW = 8;
  localparam int unsigned MAXV = 32'h0000FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_wren = 1'b0, i_rden = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [BW-1:0] i_wdata = '0;
  logic [N-1:0]  i_tick = '0;
  logic [BW-1:0] o_rdata;
  logic          o_rvalid;
  logic [N-1:0]  o_cma, o_cmb, o_ovf, o_irq;

  timer_bank_n #(.N_CH(N), .CNT_W(W), .BUS_W(BW), .ADDR_W(AW)) dut (
    .i_clk_sys(clk), .i_rst(rst), .i_wren(i_wren), .i_rden(i_rden),
    .i_addr(i_addr), .i_wdata(i_wdata), .i_tick(i_tick),
    .o_rdata(o_rdata), .o_rvalid(o_rvalid), .o_cma(o_cma),
    .o_cmb(o_cmb), .o_ovf(o_ovf), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       rv;
    bit [3:0] cma, cmb, ovf, irq;
  } ev_t;

  int unsigned m_cnt [N], m_cora [N], m_corb [N];
  bit [7:0]    m_tcr [N];
  bit [2:0]    m_tcsr [N];
  logic [31:0] rd_q [$];
  ev_t         ev_q [$];
  int          checks = 0;
  int          failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] adr(input int ch, input int off);
    adr = 8'((ch << 3) | off);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0; m_cora[k] = MAXV; m_corb[k] = MAXV;
      m_tcr[k] = 8'h00; m_tcsr[k] = 3'b000;
    end
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] a);
    int ch;
    ch = int'(a[7:3]);
    if (ch >= N) return 32'h0;
    case (a[2:0])
      3'd0: return m_cnt[ch];
      3'd1: return m_cora[ch];
      3'd2: return m_corb[ch];
      3'd3: return {24'h0, m_tcr[ch]};
      3'd4: return {29'h0, m_tcsr[ch]};
      default: return 32'h0;
    endcase
  endfunction

  // One bus/tick cycle: drive at the falling edge and predict the next edge.
  task automatic step(input bit wr, input bit rd, input logic [7:0] a,
                      input logic [31:0] wd, input logic [3:0] tk);
    ev_t e;
    bit  prev_ov, hit, wtc, eff, en, ma, mb, cl, ov;
    int unsigned wv;
    @(negedge clk);
    i_wren = wr; i_rden = rd; i_addr = a; i_wdata = wd; i_tick = tk;
    if (rd) rd_q.push_back(model_read(a));
    e.rv = rd; e.cma = '0; e.cmb = '0; e.ovf = '0; e.irq = '0;
    prev_ov = 1'b0;
    wv = wd & MAXV;
    for (int k = 0; k < N; k++) begin
      hit = wr && (int'(a[7:3]) == k);
      wtc = hit && (a[2:0] == 3'd0);
      eff = (k > 0 && m_tcr[k][5]) ? prev_ov : tk[k];
      en  = m_tcr[k][7] && eff && !wtc;
      ma  = en && (m_cnt[k] == m_cora[k]);
      mb  = en && (m_cnt[k] == m_corb[k]);
      cl  = (m_tcr[k][4:3] == 2'b01 && ma) || (m_tcr[k][4:3] == 2'b10 && mb);
      ov  = en && (m_cnt[k] == MAXV) && !cl;
      prev_ov = ov;
      if (wtc) m_cnt[k] = wv;
      else if (en) m_cnt[k] = cl ? 0 : (m_cnt[k] + 1) % (MAXV + 1);
      if (hit && a[2:0] == 3'd1) m_cora[k] = wv;
      if (hit && a[2:0] == 3'd2) m_corb[k] = wv;
      if (hit && a[2:0] == 3'd3) m_tcr[k] = wd[7:0];
      else if (m_tcr[k][6] && ma) m_tcr[k][7] = 1'b0;
      m_tcsr[k] = (m_tcsr[k] & ~((hit && a[2:0] == 3'd4) ? wd[2:0] : 3'b000)) | {ov, mb, ma};
      e.cma[k] = ma; e.cmb[k] = mb; e.ovf[k] = ov;
      e.irq[k] = |(m_tcsr[k] & m_tcr[k][2:0]);
    end
    ev_q.push_back(e);
  endtask

  task automatic wr_reg(input int ch, input int off, input logic [31:0] d);
    step(1'b1, 1'b0, adr(ch, off), d, 4'h0);
  endtask

  task automatic rd_reg(input int ch, input int off, input logic [3:0] tk);
    step(1'b0, 1'b1, adr(ch, off), 32'h0, tk);
  endtask

  // Monitor: compare every predicted cycle just after the active edge.
  always @(posedge clk) begin
    ev_t e;
    #1;
    if (!rst && ev_q.size() > 0) begin
      e = ev_q.pop_front();
      chk("rvalid", {31'h0, o_rvalid}, {31'h0, e.rv});
      chk("cma", {28'h0, o_cma}, {28'h0, e.cma});
      chk("cmb", {28'h0, o_cmb}, {28'h0, e.cmb});
      chk("ovf", {28'h0, o_ovf}, {28'h0, e.ovf});
      chk("irq", {28'h0, o_irq}, {28'h0, e.irq});
      if (e.rv) begin
        if (rd_q.size() == 0) chk("rd_queue_empty", 32'h1, 32'h0);
        else chk("rdata", o_rdata, rd_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;

    for (int off = 0; off < 8; off++) rd_reg(0, off, 4'h0);
    for (int off = 0; off < 8; off++) rd_reg(N - 1, off, 4'h0);
    rd_reg(5, 0, 4'h0);
    wr_reg(6, 1, 32'h1234);
    rd_reg(6, 1, 4'h0);

    // Clear-on-match A with a W1C landing in the match cycle.
    wr_reg(0, 1, 32'd5);
    wr_reg(0, 3, 32'h88);
    for (int i = 0; i < 5; i++) rd_reg(0, 0, 4'h1);
    step(1'b1, 1'b0, adr(0, 4), 32'h01, 4'h1);
    rd_reg(0, 4, 4'h1);
    for (int i = 0; i < 8; i++) rd_reg(0, 0, 4'h1);
    wr_reg(0, 4, 32'h01);
    rd_reg(0, 4, 4'h0);
    wr_reg(0, 3, 32'h00);

    // Overflow with interrupt, then W1C.
    wr_reg(1, 0, 32'hFFFE);
    wr_reg(1, 3, 32'h84);
    for (int i = 0; i < 3; i++) rd_reg(1, 0, 4'h2);
    wr_reg(1, 3, 32'h04);
    wr_reg(1, 4, 32'h04);
    rd_reg(1, 4, 4'h0);

    // Cascade: ch1 advances on the same edge ch0 wraps.
    wr_reg(0, 1, 32'd3);
    wr_reg(0, 0, 32'hFFFF);
    wr_reg(0, 3, 32'h80);
    wr_reg(1, 0, 32'h0);
    wr_reg(1, 3, 32'hA0);
    for (int i = 0; i < 5; i++) rd_reg(1, 0, 4'hF);
    wr_reg(0, 3, 32'h0);
    wr_reg(1, 3, 32'h0);

    // One-shot on match A.
    wr_reg(2, 0, 32'h0);
    wr_reg(2, 1, 32'd2);
    wr_reg(2, 3, 32'hC0);
    for (int i = 0; i < 6; i++) rd_reg(2, 0, 4'h4);
    rd_reg(2, 3, 4'h4);

    // TCNT write against a tick, and write+read on the same address.
    wr_reg(3, 3, 32'h80);
    step(1'b1, 1'b0, adr(3, 0), 32'h1234, 4'h8);
    rd_reg(3, 0, 4'h0);
    step(1'b1, 1'b1, adr(2, 1), 32'h0007, 4'h0);
    rd_reg(2, 1, 4'h0);

    for (int i = 0; i < 800; i++) begin
      logic [7:0]  a;
      logic [31:0] d;
      a = adr(int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
      if (a[2:0] == 3'd3) d = $urandom & 32'hFF;
      else if (a[2:0] == 3'd4) d = $urandom_range(0, 7);
      else if ($urandom_range(0, 3) == 0) d = $urandom_range(32'hFFF8, 32'hFFFF);
      else d = $urandom_range(0, 12);
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 1) == 1), a, d, 4'($urandom));
    end

    // Mid-count asynchronous reset.
    wr_reg(0, 1, 32'd1);
    wr_reg(0, 3, 32'h8F);
    for (int i = 0; i < 4; i++) rd_reg(0, 0, 4'hF);
    @(negedge clk);
    #2;
    rst = 1'b1;
    i_wren = 1'b0; i_rden = 1'b0; i_tick = '0; i_addr = '0; i_wdata = '0;
    #1;
    chk("rst_cma", {28'h0, o_cma}, 32'h0);
    chk("rst_cmb", {28'h0, o_cmb}, 32'h0);
    chk("rst_ovf", {28'h0, o_ovf}, 32'h0);
    chk("rst_irq", {28'h0, o_irq}, 32'h0);
    chk("rst_rvalid", {31'h0, o_rvalid}, 32'h0);
    chk("rst_rdata", o_rdata, 32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    rd_reg(0, 0, 4'h0);
    rd_reg(0, 1, 4'h0);
    rd_reg(0, 3, 4'h0);
    rd_reg(0, 4, 4'h0);
    step(1'b0, 1'b0, 8'h0, 32'h0, 4'h0);
    @(negedge clk);
    chk("queues_drained", 32'(rd_q.size() + ev_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
